// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the decode/branch logic and the PC sequencer.
// The master drives StartPC and the redirect requests; the slave returns the PC state.
interface pc_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] StartPC;
   logic              Stall;
   logic              BranchTaken;
   logic [ADDR_W-1:0] BranchOffset;
   logic              Jump;
   logic [ADDR_W-1:0] JumpAddr;
   logic              JumpReg;
   logic [ADDR_W-1:0] RegAddr;
   logic [ADDR_W-1:0] PC;
   logic [ADDR_W-1:0] PCPlusInc;
   logic              Misaligned;
   logic              DelayPending;

   modport master (
      output StartPC, Stall, BranchTaken, BranchOffset, Jump, JumpAddr, JumpReg, RegAddr,
      input  PC, PCPlusInc, Misaligned, DelayPending
   );

   modport slave (
      input  StartPC, Stall, BranchTaken, BranchOffset, Jump, JumpAddr, JumpReg, RegAddr,
      output PC, PCPlusInc, Misaligned, DelayPending
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stall, PC-relative branch, jump, jump-register, misaligned trap.
// Define PC_DELAY_SLOT_EN to make legal redirects take effect one instruction late (branch delay slot).
module pc_sequencer #(
   parameter int          ADDR_W     = 32,
   parameter int          ALIGN_BITS = 2,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
   input logic             Clock,
   input logic             Reset_L,
   pc_sequencer_if.slave   bus
);
   localparam logic [ADDR_W-1:0] INC       = ADDR_W'(1) << ALIGN_BITS;
   localparam logic [ADDR_W-1:0] ALIGNMASK = INC - ADDR_W'(1);
   localparam logic [ADDR_W-1:0] EXC       = ADDR_W'(EXC_VECTOR);

   typedef enum logic [0:0] {RUN, DELAY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] held_q, held_d;
   logic              mis_q, mis_d;
   logic              live_q;
`ifdef PC_DELAY_SLOT_EN
   logic              pend_q, pend_d;
`endif

   logic [ADDR_W-1:0] curPc;
   logic [ADDR_W-1:0] seqPc;
   logic [ADDR_W-1:0] target;
   logic              redirect;
   logic              targetBad;

   // Until the first edge after reset release, the PC is StartPC itself, so it tracks StartPC asynchronously.
   assign curPc = live_q ? pc_q : bus.StartPC;
   assign seqPc = curPc + INC;

   assign bus.PC         = curPc;
   assign bus.PCPlusInc  = seqPc;
   assign bus.Misaligned = mis_q;
`ifdef PC_DELAY_SLOT_EN
   assign bus.DelayPending = pend_q;
`else
   assign bus.DelayPending = 1'b0;
`endif

   always_comb begin
      redirect = 1'b1;
      if (bus.JumpReg)          target = bus.RegAddr;
      else if (bus.Jump)        target = bus.JumpAddr;
      else if (bus.BranchTaken) target = seqPc + (bus.BranchOffset << ALIGN_BITS);
      else begin
         target   = seqPc;
         redirect = 1'b0;
      end
      targetBad = redirect && ((target & ALIGNMASK) != '0);
   end

   always_comb begin
      pc_d    = curPc;
      state_d = state_q;
      held_d  = held_q;
      mis_d   = 1'b0;
`ifdef PC_DELAY_SLOT_EN
      pend_d  = pend_q;
`endif
      if (!bus.Stall) begin
`ifdef PC_DELAY_SLOT_EN
         // The delay slot executes the sequential instruction; the held target lands on the next edge.
         if (state_q == DELAY) begin
            pc_d    = held_q;
            held_d  = '0;
            pend_d  = 1'b0;
            state_d = RUN;
         end else if (targetBad) begin
            pc_d  = EXC;
            mis_d = 1'b1;
         end else if (redirect) begin
            pc_d    = seqPc;
            held_d  = target;
            pend_d  = 1'b1;
            state_d = DELAY;
         end else begin
            pc_d = seqPc;
         end
`else
         if (targetBad) begin
            pc_d  = EXC;
            mis_d = 1'b1;
         end else begin
            pc_d = target;
         end
`endif
      end
   end

   always_ff @(negedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         pc_q    <= '0;
         state_q <= RUN;
         held_q  <= '0;
         mis_q   <= 1'b0;
         live_q  <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
         pend_q  <= 1'b0;
`endif
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         held_q  <= held_d;
         mis_q   <= mis_d;
         live_q  <= 1'b1;
`ifdef PC_DELAY_SLOT_EN
         pend_q  <= pend_d;
`endif
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; state changes on the falling edge, checks run 1ns later.
// Delay-slot scenarios compile in only when PC_DELAY_SLOT_EN is defined.
module tb_pc_sequencer;
   logic Clock;
   logic Reset_L;
   int   checks;
   int   errors;

   pc_sequencer_if #(.ADDR_W(32)) bus ();

   pc_sequencer #(.ADDR_W(32), .ALIGN_BITS(2), .EXC_VECTOR(32'h0000_0180)) dut (
      .Clock   (Clock),
      .Reset_L (Reset_L),
      .bus     (bus.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clearInputs();
      bus.Stall        = 1'b0;
      bus.BranchTaken  = 1'b0;
      bus.BranchOffset = '0;
      bus.Jump         = 1'b0;
      bus.JumpAddr     = '0;
      bus.JumpReg      = 1'b0;
      bus.RegAddr      = '0;
   endtask

   task automatic applyReset(input logic [31:0] start);
      @(posedge Clock);
      clearInputs();
      bus.StartPC = start;
      Reset_L = 1'b0;
      #2;
      Reset_L = 1'b1;
   endtask

   task automatic stepEdge();
      @(negedge Clock);
      #1;
   endtask

   task automatic test_reset();
      @(posedge Clock);
      clearInputs();
      bus.StartPC = 32'h1234_5678;
      Reset_L = 1'b0;
      #1;
      bus.StartPC = 32'h0040_0000;
      #1;
      checks++;
      if (bus.PC !== 32'h0040_0000) begin
         errors++;
         $display("[TB] FAIL reset_pc actual=%h required=%h", bus.PC, 32'h0040_0000);
      end
      checks++;
      if (bus.PCPlusInc !== 32'h0040_0004) begin
         errors++;
         $display("[TB] FAIL reset_pcplusinc actual=%h required=%h", bus.PCPlusInc, 32'h0040_0004);
      end
      checks++;
      if (bus.Misaligned !== 1'b0 || bus.DelayPending !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags actual=%b%b required=00", bus.Misaligned, bus.DelayPending);
      end
      Reset_L = 1'b1;
   endtask

   task automatic test_sequential();
      logic [31:0] expPc [3];
      expPc[0] = 32'h0040_0004;
      expPc[1] = 32'h0040_0008;
      expPc[2] = 32'h0040_000C;
      for (int i = 0; i < 3; i++) begin
         stepEdge();
         checks++;
         if (bus.PC !== expPc[i]) begin
            errors++;
            $display("[TB] FAIL seq_pc[%0d] actual=%h required=%h", i, bus.PC, expPc[i]);
         end
      end
      @(posedge Clock);
      Reset_L = 1'b0;
      #1;
      checks++;
      if (bus.PC !== 32'h0040_0000) begin
         errors++;
         $display("[TB] FAIL async_reset_pc actual=%h required=%h", bus.PC, 32'h0040_0000);
      end
      Reset_L = 1'b1;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0040_0004) begin
         errors++;
         $display("[TB] FAIL post_reset_pc actual=%h required=%h", bus.PC, 32'h0040_0004);
      end
   endtask

   task automatic test_branch();
      applyReset(32'h0000_0100);
      bus.BranchTaken  = 1'b1;
      bus.BranchOffset = 32'hFFFF_FFFE;
      bus.Stall        = 1'b1;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0100) begin
         errors++;
         $display("[TB] FAIL stall_pc actual=%h required=%h", bus.PC, 32'h0000_0100);
      end
      bus.Stall = 1'b0;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_00FC) begin
         errors++;
         $display("[TB] FAIL branch_back_pc actual=%h required=%h", bus.PC, 32'h0000_00FC);
      end
      bus.BranchOffset = 32'h0000_0003;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_010C || bus.Misaligned !== 1'b0) begin
         errors++;
         $display("[TB] FAIL branch_fwd_pc actual=%h/%b required=%h/0", bus.PC, bus.Misaligned, 32'h0000_010C);
      end
      clearInputs();
   endtask

   task automatic test_priority();
      applyReset(32'h0000_0100);
      bus.JumpReg     = 1'b1;
      bus.RegAddr     = 32'h0000_2000;
      bus.Jump        = 1'b1;
      bus.JumpAddr    = 32'h0000_3001;
      bus.BranchTaken = 1'b1;
      bus.BranchOffset = 32'h0000_0010;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_2000 || bus.Misaligned !== 1'b0) begin
         errors++;
         $display("[TB] FAIL prio_jr_pc actual=%h/%b required=%h/0", bus.PC, bus.Misaligned, 32'h0000_2000);
      end
      bus.JumpReg  = 1'b0;
      bus.JumpAddr = 32'h0000_3000;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_3000) begin
         errors++;
         $display("[TB] FAIL prio_jump_pc actual=%h required=%h", bus.PC, 32'h0000_3000);
      end
      clearInputs();
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_3004 || bus.DelayPending !== 1'b0) begin
         errors++;
         $display("[TB] FAIL after_jump_pc actual=%h/%b required=%h/0", bus.PC, bus.DelayPending, 32'h0000_3004);
      end
   endtask

   task automatic test_trap();
      applyReset(32'h0000_0100);
      bus.JumpReg = 1'b1;
      bus.RegAddr = 32'h0000_2002;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0180 || bus.Misaligned !== 1'b1) begin
         errors++;
         $display("[TB] FAIL trap_pc actual=%h/%b required=%h/1", bus.PC, bus.Misaligned, 32'h0000_0180);
      end
      clearInputs();
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0184 || bus.Misaligned !== 1'b0) begin
         errors++;
         $display("[TB] FAIL trap_next_pc actual=%h/%b required=%h/0", bus.PC, bus.Misaligned, 32'h0000_0184);
      end
      bus.Jump     = 1'b1;
      bus.JumpAddr = 32'h0000_3001;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0180 || bus.Misaligned !== 1'b1) begin
         errors++;
         $display("[TB] FAIL trap_jump_pc actual=%h/%b required=%h/1", bus.PC, bus.Misaligned, 32'h0000_0180);
      end
      bus.Stall = 1'b1;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0180 || bus.Misaligned !== 1'b0) begin
         errors++;
         $display("[TB] FAIL trap_stall_pc actual=%h/%b required=%h/0", bus.PC, bus.Misaligned, 32'h0000_0180);
      end
      clearInputs();
   endtask

   task automatic test_wrap();
      applyReset(32'hFFFF_FFFC);
      #1;
      checks++;
      if (bus.PCPlusInc !== 32'h0000_0000) begin
         errors++;
         $display("[TB] FAIL wrap_plusinc_before actual=%h required=%h", bus.PCPlusInc, 32'h0);
      end
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0000 || bus.PCPlusInc !== 32'h0000_0004 || bus.Misaligned !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_pc actual=%h/%h/%b required=00000000/00000004/0", bus.PC, bus.PCPlusInc, bus.Misaligned);
      end
   endtask

`ifdef PC_DELAY_SLOT_EN
   task automatic test_delay_slot();
      applyReset(32'h0000_0100);
      bus.Jump     = 1'b1;
      bus.JumpAddr = 32'h0000_0400;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0104 || bus.DelayPending !== 1'b1) begin
         errors++;
         $display("[TB] FAIL delay_slot_pc actual=%h/%b required=%h/1", bus.PC, bus.DelayPending, 32'h0000_0104);
      end
      bus.Jump         = 1'b0;
      bus.BranchTaken  = 1'b1;
      bus.BranchOffset = 32'h0000_0040;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0400 || bus.DelayPending !== 1'b0) begin
         errors++;
         $display("[TB] FAIL delay_target_pc actual=%h/%b required=%h/0", bus.PC, bus.DelayPending, 32'h0000_0400);
      end
      applyReset(32'h0000_0100);
      bus.Jump     = 1'b1;
      bus.JumpAddr = 32'h0000_0400;
      stepEdge();
      clearInputs();
      @(posedge Clock);
      Reset_L = 1'b0;
      #1;
      checks++;
      if (bus.PC !== 32'h0000_0100 || bus.DelayPending !== 1'b0) begin
         errors++;
         $display("[TB] FAIL delay_reset_pc actual=%h/%b required=%h/0", bus.PC, bus.DelayPending, 32'h0000_0100);
      end
      Reset_L = 1'b1;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0104 || bus.DelayPending !== 1'b0) begin
         errors++;
         $display("[TB] FAIL delay_lost_pc actual=%h/%b required=%h/0", bus.PC, bus.DelayPending, 32'h0000_0104);
      end
      bus.JumpReg = 1'b1;
      bus.RegAddr = 32'h0000_0801;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0180 || bus.Misaligned !== 1'b1 || bus.DelayPending !== 1'b0) begin
         errors++;
         $display("[TB] FAIL delay_trap_pc actual=%h/%b/%b required=%h/1/0", bus.PC, bus.Misaligned, bus.DelayPending, 32'h0000_0180);
      end
      clearInputs();
   endtask
`else
   task automatic test_no_delay();
      applyReset(32'h0000_0100);
      bus.Jump     = 1'b1;
      bus.JumpAddr = 32'h0000_0400;
      stepEdge();
      checks++;
      if (bus.PC !== 32'h0000_0400 || bus.DelayPending !== 1'b0) begin
         errors++;
         $display("[TB] FAIL nodelay_jump_pc actual=%h/%b required=%h/0", bus.PC, bus.DelayPending, 32'h0000_0400);
      end
      clearInputs();
   endtask
`endif

   initial begin
      checks  = 0;
      errors  = 0;
      Reset_L = 1'b0;
      bus.StartPC = '0;
      clearInputs();
      test_reset();
      test_sequential();
      test_branch();
      test_priority();
      test_trap();
      test_wrap();
`ifdef PC_DELAY_SLOT_EN
      test_delay_slot();
`else
      test_no_delay();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer. Successor to the fixed 32-bit PC-plus-4 register.
- Adds stall, PC-relative branch, absolute jump, jump-register, a misaligned-target trap, and an optional branch-delay-slot mode.
- Sits at the front of the single-cycle datapath. Its PC output drives instruction-memory address. Redirect inputs come from the decode/branch-compare logic.

Parameters:
- ADDR_W, 32, width of PC and all address ports.
- ALIGN_BITS, 2, number of low address bits that must be zero. INC = 1<<ALIGN_BITS (default 4).
- EXC_VECTOR, 32'h00000180 (truncated to ADDR_W), PC loaded on a misaligned redirect.

Ports:
- Clock  input  1  system clock. All state updates on the falling edge.
- Reset_L  input  1  asynchronous, active-low reset.
- StartPC  input  ADDR_W  value loaded into PC while Reset_L=0.
- Stall  input  1  hold PC and state this edge.
- BranchTaken  input  1  PC-relative redirect request.
- BranchOffset  input  ADDR_W  sign-extended word offset.
- Jump  input  1  absolute redirect request.
- JumpAddr  input  ADDR_W  absolute target.
- JumpReg  input  1  register-indirect redirect request.
- RegAddr  input  ADDR_W  register target.
- PC  output  ADDR_W  current program counter.
- PCPlusInc  output  ADDR_W  PC+INC, combinational, modulo 2^ADDR_W.
- Misaligned  output  1  one-cycle pulse: the last redirect trapped.
- DelayPending  output  1  redirect latched, awaiting the delay slot (0 when the feature is compiled out).

Behaviour:
- Reset: while Reset_L=0, PC=StartPC (tracks StartPC asynchronously), Misaligned=0, DelayPending=0, state=RUN, held target cleared.
- Reset asserted mid-operation discards any pending redirect.
- First falling edge after release advances normally.
- Arithmetic, all modulo 2^ADDR_W:
  - seq = PC+INC
  - btgt = PC+INC + (BranchOffset<<ALIGN_BITS)
  - jtgt = JumpAddr
  - rtgt = RegAddr
- Selection per falling edge, priority high to low: Stall > JumpReg > Jump > BranchTaken > sequential.
  - Lower-priority requests in the same cycle are ignored.
- Misaligned check: applies to the selected redirect target only (rtgt, jtgt or btgt).
  - If target[ALIGN_BITS-1:0] != 0, PC <= EXC_VECTOR and Misaligned=1 for exactly one cycle.
  - The trap cancels any pending delay-slot redirect.
- Stall=1: PC, state, held target and DelayPending unchanged. Misaligned is cleared. Redirect inputs are ignored.
- States:
  - RUN: normal selection as above.
  - DELAY: only with the optional feature; defined there.
- Wrap-around: PC = 2^ADDR_W - INC with sequential advance gives 0. No flag is raised.
- PCPlusInc is always combinational from the current PC.

Optional Feature:
- Macro: PC_DELAY_SLOT_EN.
- Defined:
  - In RUN, a legal redirect sets PC <= seq, latches the target, sets DelayPending=1, and moves to DELAY.
  - In DELAY, the next non-stalled edge sets PC <= held target, DelayPending=0, and returns to RUN.
  - Redirect inputs asserted while in DELAY are ignored (no branch in delay slot).
  - A stall in DELAY holds the state.
  - A misaligned redirect in RUN traps immediately; it has no delay slot.
- Undefined: redirects take effect on the same edge. The state machine stays in RUN. DelayPending is tied to 0.

Test Plan:
- Reset and sequential advance: StartPC=0x00400000, release Reset_L, 3 edges -> PC 0x00400004, 0x00400008, 0x0040000C. Assert Reset_L mid-run -> PC=0x00400000 immediately (asynchronous).
- Branch: PC=0x100, BranchTaken=1, BranchOffset=0xFFFFFFFE -> PC=0x0FC. Add Stall=1 in the same cycle -> PC stays 0x100.
- Priority: JumpReg=1 (RegAddr=0x2000), Jump=1 (JumpAddr=0x3000) and BranchTaken=1 together -> PC=0x2000.
- Trap: JumpReg=1, RegAddr=0x2002 -> PC=0x180, Misaligned=1 for one cycle, then PC=0x184 with Misaligned=0.
- Wrap-around: StartPC=0xFFFFFFFC, one edge -> PC=0x00000000, PCPlusInc=0x4.
- PC_DELAY_SLOT_EN: PC=0x100, Jump=1, JumpAddr=0x400 -> PC=0x104 with DelayPending=1. Next edge -> PC=0x400 with DelayPending=0. Repeat with Reset_L pulsed during DELAY -> PC=StartPC and the redirect is lost.
